nes_controller_reader: RTL

- Polls an NES-style serial game controller and produces the parallel 8-bit `controller` button vector.
- The writeback control stage consumes this vector directly. Its `sbp` path selects `controller[rs[2:0]]` as the register write value.
- Runs free in the processor clock domain. It generates the latch and serial-clock strobes, synchronises the serial data line, and updates the button vector atomically once per frame.

---
 rtl/nes_controller_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// Polls an NES-style serial pad and presents its eight buttons as a registered, active-high vector.
// The vector is replaced only as a whole, in the single DONE cycle that ends each frame.
module nes_controller_reader #(
  parameter int unsigned CLK_DIV     = 300,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] controller,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned LatchLen = 2 * CLK_DIV;
  localparam int unsigned MaxCount = (POLL_PERIOD > LatchLen) ? POLL_PERIOD : LatchLen;
  localparam int unsigned CntW     = (MaxCount > 2) ? $clog2(MaxCount) : 1;

  localparam logic [CntW-1:0] PollLast  = CntW'(POLL_PERIOD - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(LatchLen - 1);
  localparam logic [CntW-1:0] PhaseLast = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [1:0]      sync_q;
  logic            ctrl_latch_q;
  logic            ctrl_clk_q;
  logic [7:0]      controller_q;
  logic            valid_q;
  logic            busy_q;

  // Every output flop is written together with the state that it reflects, so each output is
  // already correct in the first cycle of that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      sync_q       <= 2'b11;
      ctrl_latch_q <= 1'b0;
      ctrl_clk_q   <= 1'b0;
      controller_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ctrl_data};
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!enable) begin
            cnt_q <= '0;
          end else if (cnt_q == PollLast) begin
            cnt_q        <= '0;
            state_q      <= StLatch;
            ctrl_latch_q <= 1'b1;
            busy_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLatch: begin
          if (cnt_q == LatchLast) begin
            cnt_q        <= '0;
            bit_q        <= '0;
            state_q      <= StLow;
            ctrl_latch_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLow: begin
          if (cnt_q == PhaseLast) begin
            // Sample at the end of the low phase, when the pad has held the bit longest.
            cnt_q          <= '0;
            shift_q[bit_q] <= ~sync_q[1];
            state_q        <= StHigh;
            ctrl_clk_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (cnt_q == PhaseLast) begin
            cnt_q      <= '0;
            ctrl_clk_q <= 1'b0;
            if (bit_q == 3'd7) begin
              state_q      <= StDone;
              controller_q <= shift_q;
              valid_q      <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              state_q <= StLow;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          cnt_q   <= '0;
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_latch = ctrl_latch_q;
  assign ctrl_clk   = ctrl_clk_q;
  assign controller = controller_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule
